des_round_scan_unit: RTL and testbench
======================================

Name: des_round_scan_unit

Overview:
- Parametrised scan/trace unit for the DES round pipeline.
- Snapshots all per-round intermediate words (NUM_ROUNDS x WORD_W) on a capture request in test mode.
- Unloads the snapshot as a serial chain (sout, with scan_in refill), as a valid/ready word stream of all rounds, or as a single selected round.
- Replaces the fixed 16x32 ScanOut/SOUT arrangement with configurable geometry, unload modes and abort/overflow reporting.

Parameters:
- NUM_ROUNDS, 16, number of captured round words.
- WORD_W, 32, width of each round word.
- IDX_W, $clog2(NUM_ROUNDS), derived localparam: round index width.
- CNT_W, $clog2(NUM_ROUNDS*WORD_W+1), derived localparam: serial bit-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- test_mode  in  1  enables capture/unload; deassertion aborts.
- capture_req  in  1  single-cycle request to arm a capture.
- mode  in  2  00 serial, 01 word stream, 10 single round; 11 reserved, treated as 01. Sampled on the accepted capture_req.
- round_sel  in  IDX_W  round for mode 10, sampled with mode.
- data_in  in  NUM_ROUNDS*WORD_W  round words; round r (0-based) is bits [(r+1)*WORD_W-1 : r*WORD_W].
- data_in_valid  in  1  core signals data_in holds a completed block.
- scan_in  in  1  serial refill bit during serial shift.
- sout  out  1  serial chain output.
- snap_out  out  NUM_ROUNDS*WORD_W  snapshot register, parallel view.
- word_out  out  WORD_W  streamed round word.
- word_idx  out  IDX_W  index of word_out.
- word_valid  out  1  word_out is valid.
- word_ready  in  1  sink accepts word.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on test_mode abort.
- overflow  out  1  sticky: capture_req seen while busy.

Behaviour:
- Reset: all outputs 0, snap 0, counters 0, state IDLE. Reset is effective mid-operation at any time.
- States: IDLE, ARMED, SHIFT, STREAM, DONE.
- IDLE:
  - capture_req && test_mode -> ARMED.
  - Latch mode and round_sel.
  - Clear overflow.
  - capture_req without test_mode is ignored.
- ARMED: on data_in_valid, snap <= data_in, then:
  - mode 00 -> SHIFT, bit counter = NUM_ROUNDS*WORD_W.
  - mode 01/11 -> STREAM, idx = 0, last = NUM_ROUNDS-1.
  - mode 10 -> STREAM, idx = last = round_sel. round_sel >= NUM_ROUNDS is clamped to NUM_ROUNDS-1.
- SHIFT:
  - sout = snap[0], combinational from the register. sout = 0 outside SHIFT.
  - Each cycle: snap <= {scan_in, snap[MSB:1]}, counter decrements.
  - At counter reaching 1, move to DONE. Exactly NUM_ROUNDS*WORD_W shift cycles; first sout bit is visible the cycle after capture.
  - After completion, snap holds the scan_in bits; the first-shifted-in bit ends at bit 0.
- STREAM:
  - word_valid = 1, word_out = snap word[idx], word_idx = idx, all held stable until handshake.
  - On word_valid && word_ready: if idx == last -> DONE, else idx+1.
  - Zero-latency ready: one word per cycle is sustainable.
- DONE: done = 1 for exactly one cycle, then IDLE. busy is high in DONE.
- Abort: test_mode = 0 in ARMED, SHIFT or STREAM:
  - Next state is IDLE, aborted pulses one cycle, done is not asserted, word_valid drops.
  - snap retains its partial content.
- Overflow: capture_req while busy is ignored and sets overflow. Overflow is cleared only by the next accepted capture_req.
- Simultaneous events:
  - capture_req and data_in_valid in the same IDLE cycle: only arming occurs; the capture needs a later data_in_valid.
  - test_mode drop coinciding with the final handshake or final shift: abort wins, no done.
- snap_out is always driven from snap.

Decomposition:
- des_scan_pkg holds:
  - mode encodings: MODE_SERIAL, MODE_STREAM, MODE_SINGLE.
  - state enum type.
  - default geometry constants: DES_ROUNDS = 16, DES_HALF_W = 32.
- Single module, no sub-module. An optional des_scan_word_mux (indexed word select) may be factored out if the mux is reused elsewhere.

Test Plan:
- Serial unload, NUM_ROUNDS=16, WORD_W=32, word r = r+1 (32'h00000001..32'h00000010), scan_in = 1, mode 00:
  - 512 sout bits match LSB-first snap.
  - done at cycle 513 after capture.
  - snap_out = all ones afterward.
- Stream, mode 01, same data, word_ready toggling 1,0,1,0:
  - words 32'h00000001..32'h00000010 with word_idx 0..15, each held stable while ready = 0.
  - done after the 16th handshake.
- Single, mode 10, round_sel = 3:
  - one word 32'h00000004, word_idx = 3, then done.
  - round_sel = 20 (IDX_W = 4 wraps to 4) versus a NUM_ROUNDS=12 build with round_sel = 14: index clamped to 11.
- Abort: test_mode dropped at serial bit 100:
  - aborted pulse, no done, busy = 0 next cycle, sout = 0.
- Overflow: second capture_req during STREAM:
  - overflow = 1 and stays set through done.
  - cleared on the next accepted capture_req.
- Async reset asserted mid-SHIFT:
  - all outputs 0 immediately, state IDLE, snap = 0.

Source files
------------

// File: rtl/des_scan_pkg.sv
// Shared encodings and default geometry for the DES round scan/trace unit.
package des_scan_pkg;

    localparam logic [1:0] MODE_SERIAL = 2'b00;
    localparam logic [1:0] MODE_STREAM = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    localparam int DES_ROUNDS = 16;
    localparam int DES_HALF_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SHIFT,
        ST_STREAM,
        ST_DONE
    } scan_state_e;

endpackage

// File: rtl/des_round_scan_unit.sv
// Snapshots all DES round words in test mode and unloads them serially,
// as a valid/ready word stream, or as a single selected round.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for capture_req with test_mode
// ST_ARMED  | mode latched, waiting for data_in_valid to snapshot
// ST_SHIFT  | serial unload on sout, scan_in refills from the top
// ST_STREAM | presenting snap words idx..last on the word interface
// ST_DONE   | one-cycle completion pulse
module des_round_scan_unit
    import des_scan_pkg::*;
#(
    parameter int NUM_ROUNDS = DES_ROUNDS,
    parameter int WORD_W     = DES_HALF_W,
    localparam int IDX_W     = $clog2(NUM_ROUNDS),
    localparam int CNT_W     = $clog2(NUM_ROUNDS*WORD_W+1),
    localparam int SNAP_W    = NUM_ROUNDS*WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              test_mode,
    input  logic              capture_req,
    input  logic [1:0]        mode,
    input  logic [IDX_W-1:0]  round_sel,
    input  logic [SNAP_W-1:0] data_in,
    input  logic              data_in_valid,
    input  logic              scan_in,
    output logic              sout,
    output logic [SNAP_W-1:0] snap_out,
    output logic [WORD_W-1:0] word_out,
    output logic [IDX_W-1:0]  word_idx,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(SNAP_W);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    scan_state_e       state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic [SNAP_W-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              aborted_q, aborted_d;
    logic              overflow_q, overflow_d;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        sel_d      = sel_q;
        snap_d     = snap_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        last_d     = last_q;
        aborted_d  = 1'b0;
        overflow_d = overflow_q;

        if (capture_req && (state_q != ST_IDLE)) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (capture_req && test_mode) begin
                    state_d    = ST_ARMED;
                    mode_d     = mode;
                    // out-of-range rounds only exist for non power-of-two geometries
                    sel_d      = (32'(round_sel) >= NUM_ROUNDS) ? IDX_LAST : round_sel;
                    overflow_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (!test_mode) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (data_in_valid) begin
                    snap_d = data_in;
                    case (mode_q)
                        MODE_SERIAL: begin
                            state_d = ST_SHIFT;
                            cnt_d   = CNT_FULL;
                        end
                        MODE_SINGLE: begin
                            state_d = ST_STREAM;
                            idx_d   = sel_q;
                            last_d  = sel_q;
                        end
                        default: begin
                            state_d = ST_STREAM;
                            idx_d   = '0;
                            last_d  = IDX_LAST;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                if (!test_mode) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    snap_d = {scan_in, snap_q[SNAP_W-1:1]};
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_STREAM: begin
                if (!test_mode) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (word_ready) begin
                    if (idx_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_SERIAL;
            sel_q      <= '0;
            snap_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            aborted_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            sel_q      <= sel_d;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            aborted_q  <= aborted_d;
            overflow_q <= overflow_d;
        end
    end

    // Every output decodes straight from flops, so reset clears them at once.
    assign word_valid = (state_q == ST_STREAM);
    assign word_out   = word_valid ? snap_q[idx_q*WORD_W +: WORD_W] : '0;
    assign word_idx   = word_valid ? idx_q : '0;
    assign sout       = (state_q == ST_SHIFT) & snap_q[0];
    assign snap_out   = snap_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign aborted    = aborted_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_des_round_scan_unit.sv
// Scoreboard bench for des_round_scan_unit: stimulus pushes expected bits/words,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_des_round_scan_unit;
    import des_scan_pkg::*;

    localparam int NR   = 16;
    localparam int WW   = 32;
    localparam int SW   = NR * WW;
    localparam int NR12 = 12;
    localparam int SW12 = NR12 * WW;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] word;
    } wexp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          test_mode;
    logic          capture_req;
    logic          capture_req12;
    logic [1:0]    mode;
    logic [3:0]    round_sel;
    logic [SW-1:0] data_in;
    logic          data_in_valid;
    logic          scan_in;
    logic          word_ready;

    logic          sout, word_valid, busy, done, aborted, overflow;
    logic [SW-1:0] snap_out;
    logic [31:0]   word_out;
    logic [3:0]    word_idx;

    logic            sout12, word_valid12, busy12, done12, aborted12, overflow12;
    logic [SW12-1:0] snap_out12;
    logic [31:0]     word_out12;
    logic [3:0]      word_idx12;

    int n_cmp = 0;
    int n_err = 0;

    bit    exp_b[$];
    wexp_t exp_w[$];
    wexp_t exp_w12[$];
    wexp_t mon_e;
    bit    stall;
    logic [31:0] hold_w;
    logic [3:0]  hold_i;

    always #5 clk = ~clk;

    des_round_scan_unit #(.NUM_ROUNDS(NR), .WORD_W(WW)) u_dut (
        .clk(clk), .rst_n(rst_n), .test_mode(test_mode), .capture_req(capture_req),
        .mode(mode), .round_sel(round_sel), .data_in(data_in), .data_in_valid(data_in_valid),
        .scan_in(scan_in), .sout(sout), .snap_out(snap_out), .word_out(word_out),
        .word_idx(word_idx), .word_valid(word_valid), .word_ready(word_ready), .busy(busy),
        .done(done), .aborted(aborted), .overflow(overflow)
    );

    des_round_scan_unit #(.NUM_ROUNDS(NR12), .WORD_W(WW)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .test_mode(test_mode), .capture_req(capture_req12),
        .mode(mode), .round_sel(round_sel), .data_in(data_in[SW12-1:0]),
        .data_in_valid(data_in_valid), .scan_in(scan_in), .sout(sout12),
        .snap_out(snap_out12), .word_out(word_out12), .word_idx(word_idx12),
        .word_valid(word_valid12), .word_ready(word_ready), .busy(busy12),
        .done(done12), .aborted(aborted12), .overflow(overflow12)
    );

    task automatic chk1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: after n shifts, bit k holds original bit k+n, or refill bit k+n-SW.
    function automatic logic [SW-1:0] shifted(input logic [SW-1:0] d, input logic [SW-1:0] s,
                                              input int n);
        logic [SW-1:0] r;
        for (int k = 0; k < SW; k++) begin
            r[k] = (k + n < SW) ? d[k + n] : s[k + n - SW];
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] plan_data();
        logic [SW-1:0] d;
        for (int r = 0; r < NR; r++) d[r*WW +: WW] = 32'(r + 1);
        return d;
    endfunction

    function automatic logic [SW-1:0] rand_data();
        logic [SW-1:0] d;
        for (int r = 0; r < NR; r++) d[r*WW +: WW] = $urandom();
        return d;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (exp_b.size() > 0) chk1("sout", sout, exp_b.pop_front());
            if (word_valid) begin
                if (stall) begin
                    chk32("hold_word", word_out, hold_w);
                    chk32("hold_idx", 32'(word_idx), 32'(hold_i));
                end
                if (word_ready) begin
                    stall = 1'b0;
                    if (exp_w.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL stream_extra: got word %0h idx %0d, expected no word",
                                 word_out, word_idx);
                    end else begin
                        mon_e = exp_w.pop_front();
                        chk32("word_out", word_out, mon_e.word);
                        chk32("word_idx", 32'(word_idx), 32'(mon_e.idx));
                    end
                end else begin
                    stall  = 1'b1;
                    hold_w = word_out;
                    hold_i = word_idx;
                end
            end else begin
                stall = 1'b0;
            end
            if (word_valid12 && word_ready) begin
                if (exp_w12.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL stream12_extra: got word %0h idx %0d, expected no word",
                             word_out12, word_idx12);
                end else begin
                    mon_e = exp_w12.pop_front();
                    chk32("word_out12", word_out12, mon_e.word);
                    chk32("word_idx12", 32'(word_idx12), 32'(mon_e.idx));
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_sout"}, sout, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_aborted"}, aborted, 1'b0);
        chk1({tag, "_overflow"}, overflow, 1'b0);
        chk1({tag, "_word_valid"}, word_valid, 1'b0);
        chk32({tag, "_word_out"}, word_out, 32'h0);
        chk32({tag, "_word_idx"}, 32'(word_idx), 32'h0);
        chkv({tag, "_snap"}, snap_out, '0);
    endtask

    // Arms with data_in_valid already high (must only arm), then captures d.
    task automatic start(input logic [1:0] m, input logic [3:0] sel, input logic [SW-1:0] d);
        @(posedge clk); #1;
        test_mode     = 1'b1;
        capture_req   = 1'b1;
        mode          = m;
        round_sel     = sel;
        data_in       = {NR{$urandom()}};
        data_in_valid = 1'b1;
        @(posedge clk); #1;
        capture_req = 1'b0;
        chk1("armed_busy", busy, 1'b1);
        chk1("ovf_cleared", overflow, 1'b0);
        data_in = d;
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        data_in       = ~d;
        if (m == MODE_SERIAL) begin
            for (int k = 0; k < SW; k++) exp_b.push_back(d[k]);
        end else if (m == MODE_SINGLE) begin
            exp_w.push_back('{idx: sel, word: d[int'(sel)*WW +: WW]});
        end else begin
            for (int r = 0; r < NR; r++) exp_w.push_back('{idx: 4'(r), word: d[r*WW +: WW]});
        end
    endtask

    // rdy_pat: 0 toggle 1,0,..  1 random  2 always ready
    task automatic run(input logic [1:0] m, input logic [3:0] sel, input logic [SW-1:0] d,
                       input int rdy_pat, input int abort_at, input int ovf_at, input bit ones);
        logic [SW-1:0] s;
        int cnt;
        for (int k = 0; k < SW; k++) s[k] = ones ? 1'b1 : 1'($urandom_range(0, 1));
        start(m, sel, d);
        cnt = 0;
        while (cnt < 1000) begin
            scan_in     = (cnt < SW) ? s[cnt] : 1'b0;
            word_ready  = (rdy_pat == 0) ? (cnt % 2 == 0) :
                          (rdy_pat == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            capture_req = (cnt == ovf_at);
            if (cnt == abort_at) test_mode = 1'b0;
            @(posedge clk); #1;
            cnt++;
            if (cnt == ovf_at + 1) chk1("ovf_set", overflow, 1'b1);
            if (done || aborted) break;
        end
        capture_req = 1'b0;
        word_ready  = 1'b0;
        if (abort_at >= 0) begin
            chk1("abort_pulse", aborted, 1'b1);
            chk1("abort_no_done", done, 1'b0);
            chk1("abort_busy", busy, 1'b0);
            chk1("abort_sout", sout, 1'b0);
            chk1("abort_wvalid", word_valid, 1'b0);
            chk32("abort_cycle", 32'(cnt), 32'(abort_at + 1));
            if (m == MODE_SERIAL) chkv("abort_snap", snap_out, shifted(d, s, abort_at));
            exp_b.delete();
            exp_w.delete();
            test_mode = 1'b1;
        end else begin
            chk1("done_pulse", done, 1'b1);
            chk1("done_busy", busy, 1'b1);
            chk1("done_no_abort", aborted, 1'b0);
            if (m == MODE_SERIAL) begin
                chk32("serial_done_cycle", 32'(cnt + 1), 32'(SW + 1));
                chkv("serial_snap", snap_out, shifted(d, s, SW));
                chk32("serial_drained", 32'(exp_b.size()), 32'h0);
            end else begin
                chk32("stream_drained", 32'(exp_w.size()), 32'h0);
                if (rdy_pat == 2)
                    chk32("stream_cycles", 32'(cnt), (m == MODE_SINGLE) ? 32'd1 : 32'(NR));
            end
            if (ovf_at >= 0) chk1("ovf_through_done", overflow, 1'b1);
        end
        @(posedge clk); #1;
        chk1("post_done", done, 1'b0);
        chk1("post_busy", busy, 1'b0);
        chk1("post_aborted", aborted, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SW-1:0] d;
        int cnt;
        rst_n = 1'b0; test_mode = 1'b0; capture_req = 1'b0; capture_req12 = 1'b0;
        mode = 2'b00; round_sel = 4'd0; data_in = '0; data_in_valid = 1'b0;
        scan_in = 1'b0; word_ready = 1'b0;
        #23;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // capture_req without test_mode is ignored
        @(posedge clk); #1;
        capture_req = 1'b1;
        @(posedge clk); #1;
        capture_req = 1'b0;
        chk1("no_tm_ignored", busy, 1'b0);

        run(MODE_SERIAL, 4'd0, plan_data(), 2, -1, -1, 1'b1);
        chkv("serial_all_ones", snap_out, {SW{1'b1}});
        run(MODE_SERIAL, 4'd0, rand_data(), 2, -1, -1, 1'b0);
        run(MODE_STREAM, 4'd0, plan_data(), 0, -1, -1, 1'b0);
        run(MODE_STREAM, 4'd0, rand_data(), 2, -1, -1, 1'b0);
        run(MODE_SINGLE, 4'd3, plan_data(), 2, -1, -1, 1'b0);
        run(MODE_SINGLE, 4'(20), plan_data(), 2, -1, -1, 1'b0);

        // 12-round build clamps round_sel 14 to 11
        d = rand_data();
        @(posedge clk); #1;
        capture_req12 = 1'b1; mode = MODE_SINGLE; round_sel = 4'd14;
        @(posedge clk); #1;
        capture_req12 = 1'b0; data_in = d; data_in_valid = 1'b1;
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        exp_w12.push_back('{idx: 4'd11, word: d[11*WW +: WW]});
        word_ready = 1'b1;
        cnt = 0;
        while (!done12 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        word_ready = 1'b0;
        chk1("clamp12_done", done12, 1'b1);
        chk32("clamp12_drained", 32'(exp_w12.size()), 32'h0);
        exp_w12.delete();

        run(MODE_SERIAL, 4'd0, rand_data(), 2, 100, -1, 1'b0);
        run(MODE_SERIAL, 4'd0, rand_data(), 2, SW - 1, -1, 1'b0);
        run(MODE_STREAM, 4'd0, rand_data(), 2, NR - 1, -1, 1'b0);
        run(MODE_STREAM, 4'd0, rand_data(), 1, -1, 2, 1'b0);
        run(MODE_SERIAL, 4'd0, rand_data(), 2, -1, -1, 1'b0);
        run(2'b11, 4'd0, rand_data(), 1, -1, -1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), rand_data(), 1, -1, -1, 1'b0);
        end

        // asynchronous reset in the middle of a serial unload
        start(MODE_SERIAL, 4'd0, rand_data());
        repeat (50) begin
            scan_in = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        exp_b.delete();
        #1;
        chk_all_zero("midreset");
        @(posedge clk); #1;
        chk_all_zero("midreset_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk1("after_reset_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
